seven_segment_capture: RTL and testbench

- Inverse of the hex-to-segment encoder: samples a 7-bit segment bus driven by an external display driver and debounces it.
- Decodes each settled pattern back to a hex nibble and delivers it over a valid/ready stream.
- Keeps a 4-digit history of decoded values.
- Sits on the input side of the chip to read back or verify a display bus, or to accept digits from a keypad/display emulator.

---
 rtl/seven_segment_capture.sv | 108 ++++++++++
 tb/tb_seven_segment_capture.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_capture.sv
// Seven-segment bus capture: debounces the segment inputs, decodes each
// settled glyph to a hex nibble and streams it out with a 4-digit history.
module seven_segment_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        clear,
    input  logic [6:0]  seg_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_value,
    output logic        out_error,
    output logic [15:0] digits,
    output logic        overrun
);

    localparam logic [8:0] THRESH = 9'(STABLE_CYCLES);
    localparam logic [7:0] SAT    = 8'(STABLE_CYCLES);

    logic [6:0] seg_q;
    logic [7:0] cnt;
    logic       locked;

    logic       same;
    logic       fire;
    logic       blank;
    logic       good_ev;
    logic [3:0] dval;
    logic       derr;

    always_comb begin
        same    = (seg_in == seg_q);
        fire    = ena && same && !locked && (({1'b0, cnt} + 9'd1) >= THRESH);
        blank   = (seg_in == 7'h00);
        good_ev = fire && !blank;
    end

    // Canonical glyphs only; anything else that is lit is an error
    always_comb begin
        dval = 4'h0;
        derr = 1'b0;
        case (seg_in)
            7'h3F: dval = 4'h0;
            7'h06: dval = 4'h1;
            7'h5B: dval = 4'h2;
            7'h4F: dval = 4'h3;
            7'h66: dval = 4'h4;
            7'h6D: dval = 4'h5;
            7'h7D: dval = 4'h6;
            7'h07: dval = 4'h7;
            7'h7F: dval = 4'h8;
            7'h6F: dval = 4'h9;
            7'h77: dval = 4'hA;
            7'h7C: dval = 4'hB;
            7'h39: dval = 4'hC;
            7'h5E: dval = 4'hD;
            7'h79: dval = 4'hE;
            7'h71: dval = 4'hF;
            default: derr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q  <= 7'h00;
            cnt    <= 8'd0;
            locked <= 1'b0;
        end else if (ena) begin
            seg_q <= seg_in;
            if (!same) begin
                cnt    <= 8'd1;
                locked <= 1'b0;
            end else begin
                if (cnt < SAT) cnt <= cnt + 8'd1;
                if (fire) locked <= 1'b1;
            end
        end
    end

    // clear wins over events and transfers; tracking state is untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_value <= 4'h0;
            out_error <= 1'b0;
            digits    <= 16'h0000;
            overrun   <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
            digits    <= 16'h0000;
            overrun   <= 1'b0;
        end else if (good_ev) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                out_value <= derr ? 4'h0 : dval;
                out_error <= derr;
            end else begin
                overrun <= 1'b1;
            end
            if (!derr) digits <= {digits[11:0], dval};
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: vector table plus
// hand-written handshake, glitch, enable and reset sequences.
module tb_seven_segment_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        clear;
    logic [6:0]  seg_in;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_value;
    logic        out_error;
    logic [15:0] digits;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seven_segment_capture #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .clear     (clear),
        .seg_in    (seg_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_error (out_error),
        .digits    (digits),
        .overrun   (overrun)
    );

    typedef struct {
        logic [6:0]  seg;
        int          hold;
        int          ev;
        int          lat;
        logic [3:0]  val;
        logic        err;
        logic [15:0] dig;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hold a pattern for n cycles; count cycles with out_valid high
    task automatic run(input logic [6:0] s, input int n, output int pulses,
                       output int lat, output logic [3:0] val,
                       output logic err);
        pulses = 0;
        lat    = 0;
        val    = 4'h0;
        err    = 1'b0;
        for (int i = 1; i <= n; i++) begin
            seg_in = s;
            @(posedge clk);
            #1;
            if (out_valid) begin
                pulses++;
                if (lat == 0) lat = i;
                val = out_value;
                err = out_error;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p, l;
        logic [3:0] v;
        logic e;

        vecs[0] = '{7'h5B, 6, 1, 4, 4'h2, 1'b0, 16'h0002};
        vecs[1] = '{7'h06, 5, 1, 4, 4'h1, 1'b0, 16'h0021};
        vecs[2] = '{7'h4F, 5, 1, 4, 4'h3, 1'b0, 16'h0213};
        vecs[3] = '{7'h66, 5, 1, 4, 4'h4, 1'b0, 16'h2134};
        vecs[4] = '{7'h6D, 5, 1, 4, 4'h5, 1'b0, 16'h1345};
        vecs[5] = '{7'h49, 5, 1, 4, 4'h0, 1'b1, 16'h1345};
        vecs[6] = '{7'h00, 6, 0, 0, 4'h0, 1'b0, 16'h1345};
        vecs[7] = '{7'h77, 5, 1, 4, 4'hA, 1'b0, 16'h345A};
        vecs[8] = '{7'h5E, 5, 1, 4, 4'hD, 1'b0, 16'h45AD};
        vecs[9] = '{7'h71, 5, 1, 4, 4'hF, 1'b0, 16'h5ADF};

        rst_n     = 1'b0;
        ena       = 1'b1;
        clear     = 1'b0;
        seg_in    = 7'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 16'(out_valid), 16'h0);
        chk("rst_value", 16'(out_value), 16'h0);
        chk("rst_error", 16'(out_error), 16'h0);
        chk("rst_digits", digits, 16'h0);
        chk("rst_overrun", 16'(overrun), 16'h0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            run(vecs[i].seg, vecs[i].hold, p, l, v, e);
            chk($sformatf("v%0d_events", i), 16'(p), 16'(vecs[i].ev));
            if (vecs[i].ev > 0) begin
                chk($sformatf("v%0d_lat", i), 16'(l), 16'(vecs[i].lat));
                chk($sformatf("v%0d_value", i), 16'(v), 16'(vecs[i].val));
                chk($sformatf("v%0d_error", i), 16'(e), 16'(vecs[i].err));
            end
            chk($sformatf("v%0d_digits", i), digits, vecs[i].dig);
        end
        chk("tbl_overrun", 16'(overrun), 16'h0);

        // clear does not re-report the locked glyph
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_digits", digits, 16'h0);
        run(7'h71, 5, p, l, v, e);
        chk("clr_norepeat", 16'(p), 16'h0);

        // backpressure: first event held, second dropped
        out_ready = 1'b0;
        run(7'h7F, 5, p, l, v, e);
        chk("bp_valid", 16'(out_valid), 16'h1);
        chk("bp_value1", 16'(out_value), 16'h8);
        run(7'h6F, 5, p, l, v, e);
        chk("bp_overrun", 16'(overrun), 16'h1);
        chk("bp_held", 16'(out_value), 16'h8);
        chk("bp_digits", digits, 16'h0089);
        out_ready = 1'b1;
        step();
        chk("bp_drain", 16'(out_valid), 16'h0);

        // glitch shorter than the debounce window
        run(7'h3F, 6, p, l, v, e);
        chk("gl_first", 16'(p), 16'h1);
        chk("gl_first_val", 16'(v), 16'h0);
        run(7'h3E, 2, p, l, v, e);
        chk("gl_glitch", 16'(p), 16'h0);
        run(7'h3F, 6, p, l, v, e);
        chk("gl_resettle", 16'(p), 16'h1);
        chk("gl_resettle_lat", 16'(l), 16'h4);
        chk("gl_digits", digits, 16'h8900);

        // enable low freezes tracking
        ena = 1'b0;
        run(7'h5B, 8, p, l, v, e);
        chk("ena_frozen", 16'(p), 16'h0);
        ena = 1'b1;
        run(7'h5B, 5, p, l, v, e);
        chk("ena_resume", 16'(p), 16'h1);
        chk("ena_lat", 16'(l), 16'h4);
        chk("ena_value", 16'(v), 16'h2);
        chk("ena_digits", digits, 16'h9002);

        // overrun then clear
        out_ready = 1'b0;
        run(7'h06, 5, p, l, v, e);
        run(7'h4F, 5, p, l, v, e);
        chk("ov2_overrun", 16'(overrun), 16'h1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("ov2_clr_overrun", 16'(overrun), 16'h0);
        chk("ov2_clr_digits", digits, 16'h0);
        chk("ov2_clr_valid", 16'(out_valid), 16'h0);

        // async reset while an event is held and a new run is counting
        run(7'h66, 5, p, l, v, e);
        chk("ar_pre_valid", 16'(out_valid), 16'h1);
        run(7'h6D, 2, p, l, v, e);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 16'(out_valid), 16'h0);
        chk("ar_value", 16'(out_value), 16'h0);
        chk("ar_digits", digits, 16'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        run(7'h6D, 4, p, l, v, e);
        chk("ar_recover", 16'(p), 16'h1);
        chk("ar_recover_val", 16'(v), 16'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
